// File: rtl/phy_tx_pkg.sv
// Purpose:      shared types and constants for the TX lane merger.
// Latency:      n/a (types and constants only).
// Backpressure: n/a.
// Contents: DATA_W byte width, default FIFO depth, level width, lane/pair
//           structs, serializer phase enum and a pair-packing helper.
package phy_tx_pkg;

    localparam int DATA_W         = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int LVL_W          = $clog2(DEF_FIFO_DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } lane_slot_t;

    // l1 sits in the upper bits so the stored word reads lane1, lane0.
    typedef struct packed {
        lane_slot_t l1;
        lane_slot_t l0;
    } pair_t;

    // Which slot of the head pair the serializer looks at next.
    typedef enum logic {
        PH_LANE0 = 1'b0,
        PH_LANE1 = 1'b1
    } phase_t;

    function automatic pair_t makePair(
        input logic [DATA_W-1:0] d0,
        input logic              v0,
        input logic [DATA_W-1:0] d1,
        input logic              v1
    );
        pair_t p;
        p.l0.data  = d0;
        p.l0.valid = v0;
        p.l1.data  = d1;
        p.l1.valid = v1;
        return p;
    endfunction

endpackage

// File: rtl/mux_2x1_8bits_tx_if.sv
// Purpose:      bundle of the lane-merger datapath and status signals.
// Latency:      n/a (wires only).
// Backpressure: in_ready toward the lane source, out_ready from the consumer.
// Ports: data_in0/1, valid_in0/1, in_ready (input side); data_out, valid_out,
//        out_ready (output side); fifo_full, fifo_empty, fifo_level, lane_mismatch.
// Modports: master = the lane source / byte consumer, slave = the merger.
interface mux_2x1_8bits_tx_if;
    import phy_tx_pkg::*;

    logic [DATA_W-1:0] data_in0;
    logic [DATA_W-1:0] data_in1;
    logic              valid_in0;
    logic              valid_in1;
    logic              in_ready;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              out_ready;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              lane_mismatch;

    modport master (
        output data_in0, data_in1, valid_in0, valid_in1, out_ready,
        input  in_ready, data_out, valid_out, fifo_full, fifo_empty,
               fifo_level, lane_mismatch
    );

    modport slave (
        input  data_in0, data_in1, valid_in0, valid_in1, out_ready,
        output in_ready, data_out, valid_out, fifo_full, fifo_empty,
               fifo_level, lane_mismatch
    );

endinterface

// File: rtl/pair_fifo.sv
// Purpose:      synchronous FIFO of lane pairs, count-based full/empty.
// Latency:      pushed entry is visible at headDat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, reset (async, active-high), push/pushDat, pop, headDat,
//        full, empty, level (entries stored).
module pair_fifo
    import phy_tx_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  pair_t                        pushDat,
    input  logic                         pop,
    output pair_t                        headDat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int LvlW = $clog2(DEPTH + 1);

    pair_t            mem [DEPTH];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic [LvlW-1:0]  count;
    logic             pushOk;
    logic             popOk;

    assign pushOk = push & ~full;
    assign popOk  = pop & ~empty;

    // DEPTH is a power of two, so pointers wrap naturally; count decides
    // full versus empty when the pointers coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PtrW'(1);
            if (popOk)  rdPtr <= rdPtr + PtrW'(1);
            case ({pushOk, popOk})
                2'b10:   count <= count + LvlW'(1);
                2'b01:   count <= count - LvlW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtr] <= pushDat;
    end

    assign headDat = mem[rdPtr];
    assign full    = (count == LvlW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/mux_2x1_8bits_tx.sv
// Purpose:      merge two-lane byte pairs into one byte stream, lane0 first.
// Latency:      pair accepted at edge k -> lane0 byte valid after k+1, lane1 after k+2.
// Backpressure: in_ready = !fifo_full (registered count); output holds while out_ready=0.
// Ports: clk, reset (async, active-high), bus (slave modport): pair input with
//        in_ready, registered data_out/valid_out with out_ready, FIFO status,
//        registered lane_mismatch pulse.
module mux_2x1_8bits_tx
    import phy_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    mux_2x1_8bits_tx_if.slave        bus
);

    localparam int LvlW = $clog2(FIFO_DEPTH + 1);

    pair_t             pushPair;
    pair_t             headPair;
    logic              pairAccept;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [LvlW-1:0]   fifoLevel;

    phase_t            phase;
    phase_t            phaseNext;
    logic              outLoad;
    logic              useLane0;
    logic              headPop;
    logic [DATA_W-1:0] loadByte;

    logic [DATA_W-1:0] dataOut;
    logic              validOut;
    logic              laneMismatch;

    // Write qualifier: a pair with no valid lane carries nothing to send.
    assign pairAccept = ~fifoFull & (bus.valid_in0 | bus.valid_in1);
    assign pushPair   = makePair(bus.data_in0, bus.valid_in0,
                                 bus.data_in1, bus.valid_in1);

    pair_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_pairFifo (
        .clk     (clk),
        .reset   (reset),
        .push    (pairAccept),
        .pushDat (pushPair),
        .pop     (headPop),
        .headDat (headPair),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .level   (fifoLevel)
    );

    // Serializer phase: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) phase <= PH_LANE0;
        else       phase <= phaseNext;
    end

    // Serializer phase: next state. After loading lane0 of a pair that
    // also has lane1, park on lane1; any pop returns to lane0.
    always_comb begin
        phaseNext = phase;
        if (outLoad) phaseNext = headPop ? PH_LANE0 : PH_LANE1;
    end

    // Serializer phase: outputs. An invalid lane0 slot is skipped in the
    // same cycle by selecting lane1 directly, so no bubble is produced.
    // Every stored pair has at least one valid lane, and PH_LANE1 is only
    // entered when lane1 is valid, so the selected slot is always valid.
    always_comb begin
        outLoad  = (~validOut | bus.out_ready) & ~fifoEmpty;
        useLane0 = (phase == PH_LANE0) & headPair.l0.valid;
        headPop  = outLoad & (~useLane0 | ~headPair.l1.valid);
        loadByte = useLane0 ? headPair.l0.data : headPair.l1.data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOut      <= '0;
            validOut     <= 1'b0;
            laneMismatch <= 1'b0;
        end else begin
            if (outLoad) begin
                dataOut  <= loadByte;
                validOut <= 1'b1;
            end else if (bus.out_ready) begin
                validOut <= 1'b0;
            end
            laneMismatch <= pairAccept & (bus.valid_in0 ^ bus.valid_in1);
        end
    end

    assign bus.in_ready      = ~fifoFull;
    assign bus.data_out      = dataOut;
    assign bus.valid_out     = validOut;
    assign bus.fifo_full     = fifoFull;
    assign bus.fifo_empty    = fifoEmpty;
    assign bus.fifo_level    = fifoLevel;
    assign bus.lane_mismatch = laneMismatch;

endmodule

// File: tb/tb_mux_2x1_8bits_tx.sv
// Purpose:      self-checking bench for the TX lane merger.
// Latency:      n/a.
// Backpressure: drives out_ready stalls and random out_ready patterns.
module tb_mux_2x1_8bits_tx;
    import phy_tx_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mux_2x1_8bits_tx_if bus();

    mux_2x1_8bits_tx #(.FIFO_DEPTH(DEF_FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int nCmp = 0;
    int nErr = 0;
    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    int misGot = 0;

    // Reference model: every accepted pair contributes its valid lanes in
    // lane0, lane1 order; every output handshake records the delivered byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.in_ready && (bus.valid_in0 || bus.valid_in1)) begin
                if (bus.valid_in0) expQ.push_back(bus.data_in0);
                if (bus.valid_in1) expQ.push_back(bus.data_in1);
            end
            if (bus.valid_out && bus.out_ready) gotQ.push_back(bus.data_out);
            if (bus.lane_mismatch) misGot++;
        end
    end

    task automatic clearModel();
        expQ.delete();
        gotQ.delete();
        misGot = 0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic sendPair(input logic [7:0] d0, input logic v0,
                            input logic [7:0] d1, input logic v1);
        bit ok = 1'b0;
        bus.data_in0 = d0; bus.valid_in0 = v0;
        bus.data_in1 = d1; bus.valid_in1 = v1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.valid_in0 = 1'b0;
        bus.valid_in1 = 1'b0;
        nCmp++;
        if (!ok) begin
            nErr++;
            $display("FAIL send_accept: in_ready=%0b, required 1 within 300 cycles", bus.in_ready);
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (gotQ.size() >= expQ.size() && !bus.valid_out) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        nCmp++;
        if (!ok) begin
            nErr++;
            $display("FAIL drain: got %0d bytes, required %0d within 500 cycles", gotQ.size(), expQ.size());
        end
    endtask

    task automatic test_reset();
        #12;
        nCmp += 7;
        if (bus.valid_out !== 1'b0)     begin nErr++; $display("FAIL rst_valid_out: %b vs 0", bus.valid_out); end
        if (bus.data_out !== 8'h00)     begin nErr++; $display("FAIL rst_data_out: %h vs 00", bus.data_out); end
        if (bus.lane_mismatch !== 1'b0) begin nErr++; $display("FAIL rst_mismatch: %b vs 0", bus.lane_mismatch); end
        if (bus.fifo_level !== '0)      begin nErr++; $display("FAIL rst_level: %0d vs 0", bus.fifo_level); end
        if (bus.fifo_empty !== 1'b1)    begin nErr++; $display("FAIL rst_empty: %b vs 1", bus.fifo_empty); end
        if (bus.fifo_full !== 1'b0)     begin nErr++; $display("FAIL rst_full: %b vs 0", bus.fifo_full); end
        if (bus.in_ready !== 1'b1)      begin nErr++; $display("FAIL rst_in_ready: %b vs 1", bus.in_ready); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic       v [5];
        logic [7:0] d [5];
        logic [LVL_W-1:0] lvl0 = '0;
        logic [4:0] expV = 5'b00110;
        clearModel();
        bus.out_ready = 1'b1;
        sendPair(8'hA1, 1'b1, 8'hB2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            v[c] = bus.valid_out;
            d[c] = bus.data_out;
            if (c == 0) lvl0 = bus.fifo_level;
        end
        for (int c = 0; c < 5; c++) begin
            nCmp++;
            if (v[c] !== expV[c]) begin nErr++; $display("FAIL single_valid[%0d]: %b vs %b", c, v[c], expV[c]); end
        end
        nCmp += 4;
        if (d[1] !== 8'hA1) begin nErr++; $display("FAIL single_byte0: %h vs a1", d[1]); end
        if (d[2] !== 8'hB2) begin nErr++; $display("FAIL single_byte1: %h vs b2", d[2]); end
        if (lvl0 !== LVL_W'(1)) begin nErr++; $display("FAIL single_level_held: %0d vs 1", lvl0); end
        if (bus.fifo_level !== '0) begin nErr++; $display("FAIL single_level_end: %0d vs 0", bus.fifo_level); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int run = 0;
        int maxLvl = 0;
        clearModel();
        bus.out_ready = 1'b1;
        fork
            begin
                for (int p = 0; p < 8; p++) begin
                    sendPair(8'($urandom), 1'b1, 8'($urandom), 1'b1);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    @(negedge clk);
                    if (int'(bus.fifo_level) > maxLvl) maxLvl = int'(bus.fifo_level);
                    if (bus.valid_out) run++;
                    else if (run > 0) break;
                end
            end
        join
        @(posedge clk); #1;
        drain();
        nCmp += 3;
        if (run != 16)   begin nErr++; $display("FAIL b2b_gapless_run: %0d vs 16", run); end
        if (maxLvl > 1)  begin nErr++; $display("FAIL b2b_max_level: %0d vs <=1", maxLvl); end
        if (gotQ.size() != expQ.size()) begin nErr++; $display("FAIL b2b_count: %0d vs %0d", gotQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            nCmp++;
            if (gotQ[i] !== expQ[i]) begin nErr++; $display("FAIL b2b_byte[%0d]: %h vs %h", i, gotQ[i], expQ[i]); end
        end
    endtask

    task automatic test_mismatch();
        logic       m [3];
        logic       v [3];
        logic [7:0] d1 = 8'h00;
        clearModel();
        bus.out_ready = 1'b1;
        sendPair(8'($urandom), 1'b0, 8'h5C, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            m[c] = bus.lane_mismatch;
            v[c] = bus.valid_out;
            if (c == 1) d1 = bus.data_out;
        end
        @(posedge clk); #1;
        drain();
        nCmp += 9;
        if (m[0] !== 1'b1) begin nErr++; $display("FAIL mis_pulse: %b vs 1", m[0]); end
        if (m[1] !== 1'b0) begin nErr++; $display("FAIL mis_pulse_end: %b vs 0", m[1]); end
        if (v[0] !== 1'b0) begin nErr++; $display("FAIL mis_valid0: %b vs 0", v[0]); end
        if (v[1] !== 1'b1) begin nErr++; $display("FAIL mis_valid1: %b vs 1", v[1]); end
        if (v[2] !== 1'b0) begin nErr++; $display("FAIL mis_valid2: %b vs 0", v[2]); end
        if (d1 !== 8'h5C)  begin nErr++; $display("FAIL mis_byte: %h vs 5c", d1); end
        if (gotQ.size() != 1) begin nErr++; $display("FAIL mis_count: %0d vs 1", gotQ.size()); end
        if (misGot != 1)   begin nErr++; $display("FAIL mis_pulses: %0d vs 1", misGot); end
        if (expQ.size() != 1) begin nErr++; $display("FAIL mis_model_count: %0d vs 1", expQ.size()); end
    endtask

    task automatic test_stall();
        logic [7:0] d0 [5];
        logic [7:0] d1 [5];
        for (int p = 0; p < 5; p++) begin d0[p] = 8'($urandom); d1[p] = 8'($urandom); end
        clearModel();
        bus.out_ready = 1'b0;
        fork
            begin
                for (int p = 0; p < 5; p++) sendPair(d0[p], 1'b1, d1[p], 1'b1);
            end
            begin
                repeat (12) @(negedge clk);
                nCmp += 6;
                if (expQ.size() != 8)            begin nErr++; $display("FAIL stall_accepted: %0d bytes vs 8", expQ.size()); end
                if (bus.in_ready !== 1'b0)       begin nErr++; $display("FAIL stall_in_ready: %b vs 0", bus.in_ready); end
                if (bus.fifo_full !== 1'b1)      begin nErr++; $display("FAIL stall_full: %b vs 1", bus.fifo_full); end
                if (bus.fifo_level !== LVL_W'(4)) begin nErr++; $display("FAIL stall_level: %0d vs 4", bus.fifo_level); end
                if (bus.valid_out !== 1'b1)      begin nErr++; $display("FAIL stall_valid: %b vs 1", bus.valid_out); end
                if (bus.data_out !== d0[0])      begin nErr++; $display("FAIL stall_data: %h vs %h", bus.data_out, d0[0]); end
                repeat (3) @(negedge clk);
                nCmp++;
                if (bus.data_out !== d0[0])      begin nErr++; $display("FAIL stall_hold: %h vs %h", bus.data_out, d0[0]); end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        nCmp++;
        if (gotQ.size() != 10) begin nErr++; $display("FAIL stall_count: %0d vs 10", gotQ.size()); end
        for (int i = 0; i < 10; i++) if (i < gotQ.size()) begin
            logic [7:0] e;
            e = (i % 2 == 0) ? d0[i/2] : d1[i/2];
            nCmp++;
            if (gotQ[i] !== e) begin nErr++; $display("FAIL stall_byte[%0d]: %h vs %h", i, gotQ[i], e); end
        end
    endtask

    task automatic test_reset_mid();
        clearModel();
        bus.out_ready = 1'b0;
        for (int p = 0; p < 3; p++) sendPair(8'($urandom), 1'b1, 8'($urandom), 1'b1);
        repeat (2) @(negedge clk);
        nCmp++;
        if (bus.valid_out !== 1'b1) begin nErr++; $display("FAIL rmid_pre_valid: %b vs 1", bus.valid_out); end
        #2 reset = 1'b1;
        #1;
        nCmp += 5;
        if (bus.valid_out !== 1'b0)  begin nErr++; $display("FAIL rmid_valid: %b vs 0", bus.valid_out); end
        if (bus.data_out !== 8'h00)  begin nErr++; $display("FAIL rmid_data: %h vs 00", bus.data_out); end
        if (bus.fifo_empty !== 1'b1) begin nErr++; $display("FAIL rmid_empty: %b vs 1", bus.fifo_empty); end
        if (bus.in_ready !== 1'b1)   begin nErr++; $display("FAIL rmid_in_ready: %b vs 1", bus.in_ready); end
        if (bus.fifo_level !== '0)   begin nErr++; $display("FAIL rmid_level: %0d vs 0", bus.fifo_level); end
        clearModel();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        sendPair(8'h11, 1'b1, 8'h22, 1'b1);
        drain();
        nCmp++;
        if (gotQ.size() != 2) begin nErr++; $display("FAIL rmid_count: %0d vs 2", gotQ.size()); end
        else begin
            nCmp += 2;
            if (gotQ[0] !== 8'h11) begin nErr++; $display("FAIL rmid_byte0: %h vs 11", gotQ[0]); end
            if (gotQ[1] !== 8'h22) begin nErr++; $display("FAIL rmid_byte1: %h vs 22", gotQ[1]); end
        end
    endtask

    task automatic test_wrap();
        bit done = 1'b0;
        int nBytes = 0;
        int nMis = 0;
        clearModel();
        fork
            begin
                for (int p = 0; p < 3 * DEF_FIFO_DEPTH; p++) begin
                    logic v0, v1;
                    v0 = 1'($urandom_range(0, 1));
                    v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
                    nBytes += int'(v0) + int'(v1);
                    if (v0 != v1) nMis++;
                    sendPair(8'($urandom), v0, 8'($urandom), v1);
                    if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        nCmp += 3;
        if (expQ.size() != nBytes) begin nErr++; $display("FAIL wrap_accepted: %0d vs %0d", expQ.size(), nBytes); end
        if (gotQ.size() != nBytes) begin nErr++; $display("FAIL wrap_count: %0d vs %0d", gotQ.size(), nBytes); end
        if (misGot != nMis)        begin nErr++; $display("FAIL wrap_mismatch_pulses: %0d vs %0d", misGot, nMis); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            nCmp++;
            if (gotQ[i] !== expQ[i]) begin nErr++; $display("FAIL wrap_byte[%0d]: %h vs %h", i, gotQ[i], expQ[i]); end
        end
    endtask

    initial begin
        bus.data_in0  = 8'h00;
        bus.data_in1  = 8'h00;
        bus.valid_in0 = 1'b0;
        bus.valid_in1 = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_mismatch();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
